uart_rx: RTL and testbench

- Serial UART receiver: the receive end of the team's UART physical layer.
- Oversamples the `rx` line at a fixed clocks-per-bit rate and deserializes one frame: start bit, 8 data bits LSB first, parity bit, stop bit.
- Presents the byte on `data_out` with a one-cycle `data_ready` strobe and parity/stop error flags.
- Sits between the pad-side `rx` input and the byte-level consumer; pairs with the UART transmitter at the same bit rate.

---
 rtl/uart_rx.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- serial UART receiver (8 data bits LSB first, one parity bit,
// one stop bit), oversampled at CLKS_PER_BIT clocks per serial bit.
//
// Ports:
//   clock         system clock, all logic on the rising edge
//   reset         asynchronous active-low reset
//   rx_en         receive enable, only blocks detection of new start bits
//   rx            asynchronous serial line, idles high
//   data_out      last received byte, held between strobes
//   data_ready    one-cycle strobe: frame complete, data_out/flags valid
//   parity_error  parity mismatch in the last frame
//   stop_error    stop bit sampled low in the last frame
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (even, >= 4)
//   PARITY_ODD    0 = even parity, 1 = odd parity
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 20,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       parity_error,
    output logic       stop_error
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Expected parity bit for a byte under the configured parity sense.
    function automatic logic parity_f(input logic [7:0] d);
        return (^d) ^ ODD_BIT;
    endfunction

    state_t           state_r,  state_nxt;
    logic [CNT_W-1:0] cnt_r,    cnt_nxt;
    logic [2:0]       idx_r,    idx_nxt;
    logic [7:0]       shreg_r,  shreg_nxt;
    logic             par_bit_r, par_bit_nxt;
    logic             done_s;

    logic             rx_meta_r;   // first synchronizer stage
    logic             rx_sync_r;   // synchronized line, all decisions use this
    logic             rx_prev_r;   // one-cycle-old copy for falling-edge detect
    logic             start_s;

    // Two-flop synchronizer plus edge-detect delay; resets to idle-high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // A start needs a genuine falling edge, so a line stuck low never retriggers.
    assign start_s = rx_en & rx_prev_r & ~rx_sync_r;

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_nxt   = state_r;
        cnt_nxt     = cnt_r;
        idx_nxt     = idx_r;
        shreg_nxt   = shreg_r;
        par_bit_nxt = par_bit_r;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt = CNT_ZERO;
                idx_nxt = 3'd0;
                if (start_s) begin
                    state_nxt = ST_START;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (cnt_r == CNT_HALF) begin
                    cnt_nxt = CNT_ZERO;
                    idx_nxt = 3'd0;
                    if (!rx_sync_r) begin
                        state_nxt = ST_DATA;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt = CNT_ZERO;
                    shreg_nxt[idx_r] = rx_sync_r;
                    if (idx_r == 3'd7) begin
                        state_nxt = ST_PARITY;
                        idx_nxt   = 3'd0;
                    end else begin
                        idx_nxt = idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt     = CNT_ZERO;
                    par_bit_nxt = rx_sync_r;
                    state_nxt   = ST_STOP;
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                // Finish at mid stop bit so a following start edge is not missed.
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt   = CNT_ZERO;
                    done_s    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = CNT_ZERO;
                idx_nxt   = 3'd0;
            end
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            idx_r     <= 3'd0;
            shreg_r   <= 8'h00;
            par_bit_r <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            cnt_r     <= cnt_nxt;
            idx_r     <= idx_nxt;
            shreg_r   <= shreg_nxt;
            par_bit_r <= par_bit_nxt;
        end
    end

    // Registered outputs: byte and flags update only on frame completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out     <= 8'h00;
            data_ready   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_ready <= done_s;
            if (done_s) begin
                data_out     <= shreg_r;
                parity_error <= (parity_f(shreg_r) != par_bit_r);
                stop_error   <= ~rx_sync_r;
            end else begin
                data_out     <= data_out;
                parity_error <= parity_error;
                stop_error   <= stop_error;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (default parameters).
// Stimulus drives directed serial frames; expected bytes, flags and the
// strobe cycle are pushed into a scoreboard queue, and a monitor process
// pops and compares whenever data_ready is seen.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 20;

    logic       clock;
    logic       reset;
    logic       rx_en;
    logic       rx;
    logic [7:0] data_out;
    logic       data_ready;
    logic       parity_error;
    logic       stop_error;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       se;
        int         cy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_rdy = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_en       (rx_en),
        .rx          (rx),
        .data_out    (data_out),
        .data_ready  (data_ready),
        .parity_error(parity_error),
        .stop_error  (stop_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: compare each strobe against the scoreboard head.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (prev_rdy) chk("strobe_width", int'(data_ready), 0);
        if (data_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("data_out", int'(data_out), int'(e.d));
                chk("parity_error", int'(parity_error), int'(e.pe));
                chk("stop_error", int'(stop_error), int'(e.se));
                chk("strobe_cycle", cyc, e.cy);
            end
        end
        prev_rdy = data_ready;
    end

    // Send one frame starting at a negedge; optionally record expectation.
    task automatic frame(input logic [7:0] d, input logic p, input logic s,
                         input bit chk_en, input logic e_pe, input logic e_se);
        exp_t e;
        if (chk_en) begin
            e.d  = d;
            e.pe = e_pe;
            e.se = e_se;
            // rx is first sampled at the next posedge (T); strobe visible at T+212.
            e.cy = cyc + 1 + 212;
            sb.push_back(e);
        end
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clock);
        end
        rx = p;
        repeat (CPB) @(negedge clock);
        rx = s;
        repeat (CPB) @(negedge clock);
    endtask

    // Start a frame, assert reset at mid bit 4, check reset values, recover.
    task automatic reset_mid_frame(input logic [7:0] d);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clock);
        end
        rx = d[4];
        repeat (CPB / 2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_mid_data_out", int'(data_out), 0);
        chk("rst_mid_data_ready", int'(data_ready), 0);
        chk("rst_mid_parity_error", int'(parity_error), 0);
        chk("rst_mid_stop_error", int'(stop_error), 0);
        rx = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (300) @(negedge clock);
    endtask

    initial begin
        reset = 1'b0;
        rx_en = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_data_ready", int'(data_ready), 0);
        chk("rst_parity_error", int'(parity_error), 0);
        chk("rst_stop_error", int'(stop_error), 0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // 0xA5: four ones, even parity bit 0, good stop.
        frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        rx = 1'b1;
        repeat (30) @(negedge clock);

        // 0x3C with wrong parity bit 1.
        frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (30) @(negedge clock);

        // Short low glitch: rejected at mid start, outputs untouched.
        rx = 1'b0;
        repeat (5) @(negedge clock);
        rx = 1'b1;
        repeat (250) @(negedge clock);
        chk("glitch_data_out", int'(data_out), 8'h3C);
        chk("glitch_parity_error", int'(parity_error), 1);
        chk("glitch_stop_error", int'(stop_error), 0);

        // 0x81 with stop bit low, then line held low (break).
        frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (100) @(negedge clock);
        rx = 1'b1;
        repeat (40) @(negedge clock);

        // Disabled receiver ignores a full 0x55 frame.
        rx_en = 1'b0;
        frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rx = 1'b1;
        repeat (40) @(negedge clock);
        chk("rx_en_off_data_out", int'(data_out), 8'h81);
        rx_en = 1'b1;
        frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        rx = 1'b1;
        repeat (30) @(negedge clock);

        // Back-to-back 0xFF then 0x00, strobes 220 cycles apart.
        frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        reset_mid_frame(8'h6B);

        // Leave nonzero outputs and both flags set, then reset mid frame again.
        frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        rx = 1'b1;
        repeat (30) @(negedge clock);
        chk("pre_reset_data_out", int'(data_out), 8'hC3);
        reset_mid_frame(8'h96);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
